// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes RV32I into ALU ctrl/operands and registers them as the ID/EX entry.
// Latency 1 cycle capture-to-out_valid; holds the entry while !out_ready, in_ready drops during stall/flush.
module alu_issue_stage #(
  parameter int          XLEN         = 32,
  parameter logic [3:0]  ILLEGAL_CTRL = 4'b0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] alu_d1,
  output logic [XLEN-1:0] alu_d2,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            is_branch,
  output logic [2:0]      br_funct3,
  output logic            illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] CTRL_ADD  = 4'b0000;
  localparam logic [3:0] CTRL_SLT  = 4'b0010;
  localparam logic [3:0] CTRL_SLTU = 4'b0011;
  localparam logic [3:0] CTRL_SUB  = 4'b1000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]      ctrl;
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd;
    logic            rd_we;
    logic            is_branch;
    logic [2:0]      br_funct3;
    logic            illegal;
  } entry_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd_f;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;

  assign opcode = instr[6:0];
  assign rd_f   = instr[11:7];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {instr[31:12], 12'b0};

  entry_t dec;
  logic   legal;

  always_comb begin
    dec       = '0;
    dec.rd    = rd_f;
    legal     = 1'b1;
    case (opcode)
      OPC_OP: begin
        dec.d1    = rs1_data;
        dec.d2    = rs2_data;
        dec.ctrl  = {funct7[5], funct3};
        dec.rd_we = 1'b1;
        legal     = (funct7 == F7_BASE) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        dec.d1    = rs1_data;
        dec.d2    = imm_i;
        dec.ctrl  = {1'b0, funct3};
        dec.rd_we = 1'b1;
        if (funct3 == 3'b001) begin
          legal = (funct7 == F7_BASE);
        end else if (funct3 == 3'b101) begin
          dec.ctrl = {instr[30], 3'b101};
          legal    = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        end
      end
      OPC_LUI: begin
        dec.ctrl  = CTRL_ADD;
        dec.d2    = imm_u;
        dec.rd_we = 1'b1;
      end
      OPC_AUIPC: begin
        dec.ctrl  = CTRL_ADD;
        dec.d1    = pc;
        dec.d2    = imm_u;
        dec.rd_we = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        // ALU only forms the link value pc+4; target math lives elsewhere
        dec.ctrl  = CTRL_ADD;
        dec.d1    = pc;
        dec.d2    = XLEN'(4);
        dec.rd_we = 1'b1;
        if (opcode == OPC_JALR) legal = (funct3 == 3'b000);
      end
      OPC_LOAD: begin
        dec.ctrl  = CTRL_ADD;
        dec.d1    = rs1_data;
        dec.d2    = imm_i;
        dec.rd_we = 1'b1;
      end
      OPC_STORE: begin
        dec.ctrl       = CTRL_ADD;
        dec.d1         = rs1_data;
        dec.d2         = imm_s;
        dec.store_data = rs2_data;
      end
      OPC_BRANCH: begin
        dec.d1        = rs1_data;
        dec.d2        = rs2_data;
        dec.is_branch = 1'b1;
        dec.br_funct3 = funct3;
        case (funct3[2:1])
          2'b00:   dec.ctrl = CTRL_SUB;
          2'b10:   dec.ctrl = CTRL_SLT;
          2'b11:   dec.ctrl = CTRL_SLTU;
          default: legal    = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      dec.ctrl      = ILLEGAL_CTRL;
      dec.rd_we     = 1'b0;
      dec.is_branch = 1'b0;
      dec.illegal   = 1'b1;
    end
    if (rd_f == 5'd0) dec.rd_we = 1'b0;
  end

  logic   out_valid_q, out_valid_d;
  entry_t entry_q, entry_d;
  logic   capture;

  // Flush blocks acceptance so the upstream instruction is retried, not lost
  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign capture  = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    entry_d     = entry_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d = 1'b1;
      entry_d     = dec;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      entry_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      entry_q     <= entry_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign alu_ctrl   = entry_q.ctrl;
  assign alu_d1     = entry_q.d1;
  assign alu_d2     = entry_q.d2;
  assign store_data = entry_q.store_data;
  assign rd         = entry_q.rd;
  assign rd_we      = entry_q.rd_we;
  assign is_branch  = entry_q.is_branch;
  assign br_funct3  = entry_q.br_funct3;
  assign illegal    = entry_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vector table plus stall, flush and reset sequences.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_d1, alu_d2, store_data;
  logic [4:0]  rd;
  logic        rd_we, is_branch, illegal;
  logic [2:0]  br_funct3;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_ctrl(alu_ctrl), .alu_d1(alu_d1), .alu_d2(alu_d2),
    .store_data(store_data), .rd(rd), .rd_we(rd_we), .is_branch(is_branch),
    .br_funct3(br_funct3), .illegal(illegal)
  );

  typedef struct packed {
    logic [31:0] instr, pc, rs1, rs2;
    logic [3:0]  ctrl;
    logic [31:0] d1, d2, sd;
    logic [4:0]  rd;
    logic        we, br;
    logic [2:0]  bf3;
    logic        ill;
    logic        chk_data;
  } vec_t;

  vec_t vecs[$];
  int   n_applied = 0;
  int   n_miss    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [31:0] i, p, r1, r2, input logic [3:0] c,
                     input logic [31:0] d1, d2, sd, input logic [4:0] r,
                     input logic we, br, input logic [2:0] bf3,
                     input logic ill, input logic cd);
    vec_t v;
    v = '{instr:i, pc:p, rs1:r1, rs2:r2, ctrl:c, d1:d1, d2:d2, sd:sd, rd:r,
          we:we, br:br, bf3:bf3, ill:ill, chk_data:cd};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [31:0] i, p, r1, r2);
    instr = i; pc = p; rs1_data = r1; rs2_data = r2;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " out_valid"},  {31'b0, out_valid}, 32'd0);
    chk({tag, " alu_ctrl"},   {28'b0, alu_ctrl},  32'd0);
    chk({tag, " alu_d1"},     alu_d1,             32'd0);
    chk({tag, " alu_d2"},     alu_d2,             32'd0);
    chk({tag, " store_data"}, store_data,         32'd0);
    chk({tag, " rd"},         {27'b0, rd},        32'd0);
    chk({tag, " rd_we"},      {31'b0, rd_we},     32'd0);
    chk({tag, " is_branch"},  {31'b0, is_branch}, 32'd0);
    chk({tag, " br_funct3"},  {29'b0, br_funct3}, 32'd0);
    chk({tag, " illegal"},    {31'b0, illegal},   32'd0);
  endtask

  initial begin
    //   instr         pc          rs1           rs2          ctrl  d1            d2            store         rd  we br f3 ill chk
    add(32'h002081B3, 32'h0,     32'd5,        32'd7,       4'h0, 32'd5,        32'd7,        32'h0,        5'd3, 1,0,3'd0,0,1); // ADD x3,x1,x2
    add(32'h403100B3, 32'h0,     32'd10,       32'd3,       4'h8, 32'd10,       32'd3,        32'h0,        5'd1, 1,0,3'd0,0,1); // SUB
    add(32'h40335293, 32'h0,     32'h80000000, 32'h0,       4'hD, 32'h80000000, 32'h403,      32'h0,        5'd5, 1,0,3'd0,0,1); // SRAI x5,x6,3
    add(32'h00335293, 32'h0,     32'h80000000, 32'h0,       4'h5, 32'h80000000, 32'h3,        32'h0,        5'd5, 1,0,3'd0,0,1); // SRLI
    add(32'h123450B7, 32'h40,    32'hAAAA,     32'hBBBB,    4'h0, 32'h0,        32'h12345000, 32'h0,        5'd1, 1,0,3'd0,0,1); // LUI
    add(32'h00001117, 32'h100,   32'hAAAA,     32'h0,       4'h0, 32'h100,      32'h1000,     32'h0,        5'd2, 1,0,3'd0,0,1); // AUIPC
    add(32'hFFF00213, 32'h0,     32'h0,        32'h0,       4'h0, 32'h0,        32'hFFFFFFFF, 32'h0,        5'd4, 1,0,3'd0,0,1); // ADDI -1
    add(32'h0020A423, 32'h0,     32'h1000,     32'hDEADBEEF,4'h0, 32'h1000,     32'h8,        32'hDEADBEEF, 5'd8, 0,0,3'd0,0,1); // SW
    add(32'h00208863, 32'h0,     32'd3,        32'd3,       4'h8, 32'd3,        32'd3,        32'h0,        5'd16,0,1,3'd0,0,1); // BEQ
    add(32'h0020E863, 32'h0,     32'd1,        32'd2,       4'h3, 32'd1,        32'd2,        32'h0,        5'd16,0,1,3'd6,0,1); // BLTU
    add(32'h0020D863, 32'h0,     32'd1,        32'd2,       4'h2, 32'd1,        32'd2,        32'h0,        5'd16,0,1,3'd5,0,1); // BGE
    add(32'h000000EF, 32'h200,   32'h9,        32'h0,       4'h0, 32'h200,      32'h4,        32'h0,        5'd1, 1,0,3'd0,0,1); // JAL x1
    add(32'h00008067, 32'h300,   32'h9,        32'h0,       4'h0, 32'h300,      32'h4,        32'h0,        5'd0, 0,0,3'd0,0,1); // JALR x0
    add(32'hFFC12383, 32'h0,     32'h2000,     32'h0,       4'h0, 32'h2000,     32'hFFFFFFFC, 32'h0,        5'd7, 1,0,3'd0,0,1); // LW x7,-4
    add(32'h003130B3, 32'h0,     32'd4,        32'd9,       4'h3, 32'd4,        32'd9,        32'h0,        5'd1, 1,0,3'd0,0,1); // SLTU
    add(32'h00208033, 32'h0,     32'd4,        32'd9,       4'h0, 32'd4,        32'd9,        32'h0,        5'd0, 0,0,3'd0,0,1); // ADD x0
    add(32'h0000007F, 32'h0,     32'd1,        32'd2,       4'h0, 32'h0,        32'h0,        32'h0,        5'd0, 0,0,3'd0,1,0); // opcode 7F
    add(32'h0020A863, 32'h0,     32'd1,        32'd2,       4'h0, 32'h0,        32'h0,        32'h0,        5'd0, 0,0,3'd0,1,0); // BRANCH f3=010
    add(32'h402090B3, 32'h0,     32'd1,        32'd2,       4'h0, 32'h0,        32'h0,        32'h0,        5'd0, 0,0,3'd0,1,0); // OP f7=20 f3=001
    add(32'h40109093, 32'h0,     32'd1,        32'd2,       4'h0, 32'h0,        32'h0,        32'h0,        5'd0, 0,0,3'd0,1,0); // SLLI f7=20

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(32'h0, 32'h0, 32'h0, 32'h0);
    step(); step();
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    #1;
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);

    // Back-to-back decode table, one entry per cycle
    foreach (vecs[k]) begin
      drive(vecs[k].instr, vecs[k].pc, vecs[k].rs1, vecs[k].rs2);
      in_valid = 1'b1;
      step();
      chk($sformatf("v%0d out_valid", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("v%0d alu_ctrl", k),  {28'b0, alu_ctrl},  {28'b0, vecs[k].ctrl});
      chk($sformatf("v%0d rd_we", k),     {31'b0, rd_we},     {31'b0, vecs[k].we});
      chk($sformatf("v%0d is_branch", k), {31'b0, is_branch}, {31'b0, vecs[k].br});
      chk($sformatf("v%0d illegal", k),   {31'b0, illegal},   {31'b0, vecs[k].ill});
      if (vecs[k].chk_data) begin
        chk($sformatf("v%0d alu_d1", k),     alu_d1,             vecs[k].d1);
        chk($sformatf("v%0d alu_d2", k),     alu_d2,             vecs[k].d2);
        chk($sformatf("v%0d store_data", k), store_data,         vecs[k].sd);
        chk($sformatf("v%0d rd", k),         {27'b0, rd},        {27'b0, vecs[k].rd});
        chk($sformatf("v%0d br_funct3", k),  {29'b0, br_funct3}, {29'b0, vecs[k].bf3});
      end
    end
    in_valid = 1'b0;
    step();
    chk("drain out_valid", {31'b0, out_valid}, 32'd0);

    // Stall: entry A held for 3 cycles while B waits, then B taken exactly once
    drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
    in_valid = 1'b1;
    step();
    chk("stall A captured d1", alu_d1, 32'd5);
    out_ready = 1'b0;
    drive(32'h403100B3, 32'h0, 32'd10, 32'd3);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d in_ready", c), {31'b0, in_ready}, 32'd0);
      step();
      chk($sformatf("stall%0d out_valid", c), {31'b0, out_valid}, 32'd1);
      chk($sformatf("stall%0d alu_ctrl", c),  {28'b0, alu_ctrl},  32'h0);
      chk($sformatf("stall%0d alu_d1", c),    alu_d1,             32'd5);
      chk($sformatf("stall%0d alu_d2", c),    alu_d2,             32'd7);
      chk($sformatf("stall%0d rd", c),        {27'b0, rd},        32'd3);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall in_ready", {31'b0, in_ready}, 32'd1);
    step();
    chk("unstall B out_valid", {31'b0, out_valid}, 32'd1);
    chk("unstall B alu_ctrl",  {28'b0, alu_ctrl},  32'h8);
    chk("unstall B alu_d1",    alu_d1,             32'd10);
    in_valid = 1'b0;
    step();
    chk("no duplicate B", {31'b0, out_valid}, 32'd0);

    // Flush with an instruction waiting: it must be retried afterward
    drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
    in_valid = 1'b1;
    step();
    chk("pre-flush out_valid", {31'b0, out_valid}, 32'd1);
    drive(32'h123450B7, 32'h0, 32'h0, 32'h0);
    flush = 1'b1;
    #1;
    chk("flush in_ready", {31'b0, in_ready}, 32'd0);
    step();
    chk("flush out_valid", {31'b0, out_valid}, 32'd0);
    flush = 1'b0;
    #1;
    chk("post-flush in_ready", {31'b0, in_ready}, 32'd1);
    step();
    chk("retry out_valid", {31'b0, out_valid}, 32'd1);
    chk("retry alu_d2",    alu_d2,             32'h12345000);
    chk("retry rd",        {27'b0, rd},        32'd1);
    in_valid = 1'b0;
    step();
    chk("retry drained", {31'b0, out_valid}, 32'd0);

    // Reset in the middle of a stall discards the held entry
    drive(32'h0020A423, 32'h0, 32'h1000, 32'hDEADBEEF);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    chk("pre-reset store_data", store_data, 32'hDEADBEEF);
    step();
    rst_n = 1'b0;
    step();
    chk_zero_outputs("mid-stall reset");
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("after reset in_ready", {31'b0, in_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer side of the ALU interface.
- Decodes an RV32I instruction into the 4-bit ALU control code and selects the two ALU operands (register, immediate, PC or constant).
- Registers the result into the ID/EX pipeline register, with a valid/ready handshake, stall and flush.
- Sits between register-file read and the combinational ALU; its outputs drive the ALU's control/d1/d2 inputs directly.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- ILLEGAL_CTRL, 4'b0000, control code emitted alongside an illegal instruction.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  stage can accept this cycle
- instr  in  32  raw instruction word
- pc  in  32  instruction address
- rs1_data  in  32  register-file read port 1
- rs2_data  in  32  register-file read port 2
- flush  in  1  kill the registered entry (branch mispredict/trap)
- out_valid  out  1  registered entry is valid
- out_ready  in  1  EX stage consumes the entry this cycle
- alu_ctrl  out  4  ALU control code
- alu_d1  out  32  ALU operand 1
- alu_d2  out  32  ALU operand 2
- store_data  out  32  rs2_data captured for stores
- rd  out  5  destination register
- rd_we  out  1  writes rd (0 for branch/store/illegal, and 0 when rd==0)
- is_branch  out  1  branch compare op
- br_funct3  out  3  funct3 of the branch
- illegal  out  1  unsupported opcode/funct combination

Behaviour:
- **Reset:** when rst_n==0 at a clk edge, every output register clears to 0 (out_valid, alu_ctrl, alu_d1, alu_d2, store_data, rd, rd_we, is_branch, br_funct3, illegal). in_ready is combinational and reads 1 after reset. A reset mid-handshake discards the held entry.
- **Handshake:**
  - in_ready = !out_valid || out_ready.
  - Capture occurs when in_valid && in_ready; latency is 1 cycle from capture to out_valid.
  - While out_valid && !out_ready, all outputs hold stable (stall).
  - If out_ready && !(in_valid && in_ready), out_valid goes to 0 next cycle.
  - Back-to-back throughput is 1 instruction per cycle.
- **Flush:**
  - flush==1 forces out_valid to 0 next cycle, overriding capture.
  - in_ready is forced 0 during flush, so no instruction is lost silently.
  - Data registers may keep stale values.
- **Control encoding:**
  - 0000 ADD, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 0110 OR, 0111 AND, 1000 SUB, 1101 SRA.
  - For OP: ctrl = {funct7[5], funct3}. Legal only when funct7 is 0000000, or 0100000 with funct3 of 000 or 101.
- **Decode by opcode:**
  - OP (0110011): d1=rs1, d2=rs2, rd_we=1.
  - OP-IMM (0010011): d1=rs1, d2=sext(I-imm).
    - ctrl = {0, funct3}, except funct3==101 where ctrl = {instr[30], 101}.
    - For SLLI/SRLI/SRAI, instr[31:25] must be 0000000 or (SRAI only) 0100000, else illegal.
    - d2 for shifts is the full immediate; the ALU uses [4:0].
  - LUI (0110111): ctrl=ADD, d1=0, d2={U-imm, 12'b0}.
  - AUIPC (0010111): ctrl=ADD, d1=pc, d2={U-imm, 12'b0}.
  - JAL (1101111) / JALR (1100111, funct3 must be 000): ctrl=ADD, d1=pc, d2=4 (link value).
  - LOAD (0000011): ctrl=ADD, d1=rs1, d2=sext(I-imm), rd_we=1.
  - STORE (0100011): ctrl=ADD, d1=rs1, d2=sext(S-imm), store_data=rs2, rd_we=0.
  - BRANCH (1100011): d1=rs1, d2=rs2, is_branch=1, rd_we=0.
    - BEQ/BNE use SUB; BLT/BGE use SLT; BLTU/BGEU use SLTU.
    - funct3 010 or 011 is illegal.
- **Illegal instructions:** any other opcode, or an illegal funct combination, gives illegal=1, ctrl=ILLEGAL_CTRL, rd_we=0, is_branch=0. The entry still flows through the handshake.
- **rd == x0:** rd_we is forced to 0 whenever rd==0.

Test Plan:
- Reset, then ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle out_valid=1, alu_ctrl=0000, d1=5, d2=7, rd=3, rd_we=1.
- SUB x1,x2,x3 (0x403100B3) -> ctrl=1000. SRAI x5,x6,3 (0x40335293), rs1=0x80000000 -> ctrl=1101, d2=0x403.
- LUI x1,0x12345 (0x123450B7) -> ctrl=0000, d1=0, d2=0x12345000. AUIPC with pc=0x100 -> d1=0x100.
- Stall: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; raise out_ready -> next instruction captured the same cycle, no drop or duplicate.
- Flush while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, in_ready=0 during flush, new instruction presented again and captured afterward.
- Opcode 0x7F, and BRANCH funct3=010 -> illegal=1, ctrl=0000, rd_we=0. rst_n=0 mid-stall -> all outputs 0 next edge.
